// File: rtl/fifo_protocol_checker_pkg.sv
// Shared definitions for the FIFO protocol checker: rule indices and the
// error-vector type.
package fifo_chk_pkg;

    localparam int ERR_W = 6;

    typedef enum logic [2:0] {
        ERR_EMPTY  = 3'd0,
        ERR_FULL   = 3'd1,
        ERR_OVF    = 3'd2,
        ERR_UNF    = 3'd3,
        ERR_DATA   = 3'd4,
        ERR_THRESH = 3'd5
    } err_idx_e;

    typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/fifo_protocol_checker_model.sv
// Shadow ring of the FIFO under check: write/read pointers, occupancy and
// the head entry. Only operations already judged legal reach this block.
module fifo_chk_model #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             legal_push_i,
    input  logic             legal_pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    import fifo_chk_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] ring_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Ring storage holds no reset; stale entries are never read while count is 0.
    always_ff @(posedge clk_i) begin
        if (legal_push_i) begin
            ring_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer advance with wrap at DEPTH-1, occupancy tracks push-only / pop-only.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (legal_push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (legal_pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({legal_push_i, legal_pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Model state register; reset drops all occupancy immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = ring_q[rd_ptr_q];

endmodule

// File: rtl/fifo_protocol_checker.sv
// Whitebox FIFO protocol checker. Compares the FIFO's flags and read data
// against a shadow model every cycle and reports rule violations as a
// registered pulse vector, sticky bits and a saturating error counter.
module fifo_protocol_checker
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2,
    parameter int CNT_W = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_out_i,
    input  logic             full_i,
    input  logic             empty_i,
    input  logic             almost_full_i,
    input  logic             almost_empty_i,
    output logic [ERR_W-1:0] err_vec_o,
    output logic [ERR_W-1:0] err_sticky_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CW-1:0]    model_count_o
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

    logic [CW-1:0]    model_count;
    logic [WIDTH-1:0] model_head;
    logic             at_empty, at_full;
    logic             ovf, unf;
    logic             legal_push, legal_pop;

    err_vec_t         err_vec_q,    err_vec_d;
    err_vec_t         err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q,  err_count_d;

    assign at_empty   = (model_count == '0);
    assign at_full    = (model_count == FULL_C);
    assign ovf        = push_i & ~pop_i & at_full;
    assign unf        = pop_i & at_empty;
    // A pop at full frees a slot in the same cycle, so push alongside it is legal.
    assign legal_push = push_i & ~ovf;
    assign legal_pop  = pop_i & ~at_empty;

    fifo_chk_model #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_model (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .legal_push_i (legal_push),
        .legal_pop_i  (legal_pop),
        .wdata_i      (data_in_i),
        .count_o      (model_count),
        .head_o       (model_head)
    );

    // Rule comparators against the pre-update occupancy.
    always_comb begin
        err_vec_d             = '0;
        err_vec_d[ERR_EMPTY]  = (empty_i != at_empty);
        err_vec_d[ERR_FULL]   = (full_i != at_full);
        err_vec_d[ERR_OVF]    = ovf;
        err_vec_d[ERR_UNF]    = unf;
        err_vec_d[ERR_DATA]   = legal_pop & (data_out_i != model_head);
        err_vec_d[ERR_THRESH] = (almost_full_i  != (model_count >= AF_C)) |
                                (almost_empty_i != (model_count <= AE_C));
`ifndef SYNTHESIS
        if ($isunknown(empty_i))                       err_vec_d[ERR_EMPTY]  = 1'b1;
        if ($isunknown(full_i))                        err_vec_d[ERR_FULL]   = 1'b1;
        if ($isunknown(push_i))                        err_vec_d[ERR_OVF]    = 1'b1;
        if ($isunknown(pop_i))                         err_vec_d[ERR_UNF]    = 1'b1;
        if (legal_pop && $isunknown(data_out_i))       err_vec_d[ERR_DATA]   = 1'b1;
        if ($isunknown({almost_full_i, almost_empty_i})) err_vec_d[ERR_THRESH] = 1'b1;
`endif
    end

    // Sticky accumulation and saturating counter; clear wins over new errors.
    always_comb begin
        err_sticky_d = err_sticky_q | err_vec_d;
        err_count_d  = err_count_q;
        if ((err_vec_d != '0) && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        if (clear_i) begin
            err_sticky_d = '0;
            err_count_d  = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_vec_q    <= '0;
            err_sticky_q <= '0;
            err_count_q  <= '0;
        end else begin
            err_vec_q    <= err_vec_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_vec_o     = err_vec_q;
    assign err_sticky_o  = err_sticky_q;
    assign err_count_o   = err_count_q;
    assign model_count_o = model_count;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Scoreboard bench: the stimulus process drives a (mostly) well-behaved FIFO
// interface derived from a queue-based reference, pushes the expected checker
// response, and a monitor compares it one edge later.
module tb_fifo_protocol_checker;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;
    localparam int CN = 3;

    logic         clk = 1'b0;
    logic         rst_n, clear, push, pop;
    logic [W-1:0] din, dout;
    logic         full, empty, af, ae;
    logic [5:0]   err_vec, err_sticky;
    logic [CN-1:0] err_count;
    logic [2:0]   model_count;

    always #5 clk = ~clk;

    fifo_protocol_checker #(
        .WIDTH (W), .DEPTH (D), .AF_TH (AF), .AE_TH (AE), .CNT_W (CN)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .push_i         (push),
        .pop_i          (pop),
        .data_in_i      (din),
        .data_out_i     (dout),
        .full_i         (full),
        .empty_i        (empty),
        .almost_full_i  (af),
        .almost_empty_i (ae),
        .err_vec_o      (err_vec),
        .err_sticky_o   (err_sticky),
        .err_count_o    (err_count),
        .model_count_o  (model_count)
    );

    typedef struct packed {
        logic [5:0]    ev;
        logic [5:0]    st;
        logic [CN-1:0] ec;
        logic [2:0]    mc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [W-1:0]  ref_q[$];
    logic [5:0]    ref_st;
    logic [CN-1:0] ref_ec;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock edge of driven stimulus.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err_vec",     32'(err_vec),     32'(e.ev));
            check("err_sticky",  32'(err_sticky),  32'(e.st));
            check("err_count",   32'(err_count),   32'(e.ec));
            check("model_count", 32'(model_count), 32'(e.mc));
        end
    end

    // One cycle of stimulus. corrupt: [0] empty flag, [1] full flag,
    // [4] read data, [5] almost_full flag. Other flags track a correct FIFO.
    task automatic step(input bit ps, input bit pp, input logic [W-1:0] d,
                        input logic [5:0] corrupt, input bit clr);
        int         n;
        logic [5:0] ev;
        exp_t       x;
        @(negedge clk);
        n     = ref_q.size();
        empty = (n == 0) ^ corrupt[0];
        full  = (n == D) ^ corrupt[1];
        af    = (n >= AF) ^ corrupt[5];
        ae    = (n <= AE);
        dout  = (n > 0) ? ref_q[0] : W'($urandom);
        if (corrupt[4]) dout = dout ^ 8'h03;
        push  = ps;
        pop   = pp;
        din   = d;
        clear = clr;

        ev    = '0;
        ev[0] = (empty != (n == 0));
        ev[1] = (full != (n == D));
        ev[2] = ps && !pp && (n == D);
        ev[3] = pp && (n == 0);
        ev[4] = pp && (n > 0) && (dout != ref_q[0]);
        ev[5] = (af != (n >= AF)) || (ae != (n <= AE));

        if (pp && n > 0) void'(ref_q.pop_front());
        if (ps && !ev[2]) ref_q.push_back(d);

        if (clr) begin
            ref_st = '0;
            ref_ec = '0;
        end else begin
            ref_st = ref_st | ev;
            if (ev != 0 && ref_ec != '1) ref_ec = ref_ec + 1'b1;
        end
        x.ev = ev;
        x.st = ref_st;
        x.ec = ref_ec;
        x.mc = 3'(ref_q.size());
        exp_q.push_back(x);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 8'h00, 6'd0, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 0; push = 0; pop = 0; din = '0; dout = '0;
        full = 0; empty = 1; af = 0; ae = 1;
        ref_st = '0; ref_ec = '0;
        repeat (3) @(negedge clk);
        check("rst_err_vec", 32'(err_vec), 32'd0);
        check("rst_sticky",  32'(err_sticky), 32'd0);
        check("rst_count",   32'(err_count), 32'd0);
        check("rst_model",   32'(model_count), 32'd0);
        rst_n = 1'b1;

        // 1: idle with a correct FIFO
        idle(3);
        // 2: fill and drain
        step(1, 0, 8'h11, 6'd0, 0);
        step(1, 0, 8'h22, 6'd0, 0);
        step(1, 0, 8'h33, 6'd0, 0);
        step(1, 0, 8'h44, 6'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 6'd0, 0);
        // 3: overflow at full, then push&pop at full
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h60 + i), 6'd0, 0);
        step(1, 0, 8'h55, 6'd0, 0);
        step(1, 1, 8'h66, 6'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 6'd0, 0);
        // 4: pop at empty with push
        step(1, 1, 8'hA5, 6'd0, 0);
        step(0, 1, 8'h00, 6'd0, 0);
        // 5: data mismatch; empty flag wrong at count 0
        step(1, 0, 8'h11, 6'd0, 0);
        step(0, 1, 8'h00, 6'b010000, 0);
        step(0, 0, 8'h00, 6'b000001, 0);
        // 6: clear in an error cycle, threshold and full-flag errors
        step(0, 0, 8'h00, 6'b100000, 0);
        step(0, 0, 8'h00, 6'b000010, 0);
        step(0, 0, 8'h00, 6'b000001, 1);
        idle(1);
        // counter saturation
        for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 6'b000010, 0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] c;
            c = ($urandom_range(0, 9) == 0) ? (6'($urandom) & 6'b110011) : 6'd0;
            step(1'($urandom), 1'($urandom), 8'($urandom), c, $urandom_range(0, 19) == 0);
        end

        // reset mid-stream at count 2
        step(0, 0, 8'h00, 6'd0, 1);
        while (ref_q.size() > 0) step(0, 1, 8'h00, 6'd0, 0);
        step(1, 0, 8'hC1, 6'd0, 0);
        step(1, 0, 8'hC2, 6'd0, 0);
        step(0, 0, 8'h00, 6'b000001, 0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_model", 32'(model_count), 32'd2);
        rst_n = 1'b0;
        push = 0; pop = 0; clear = 0; empty = 1; full = 0; af = 0; ae = 1;
        #1;
        check("async_rst_model",  32'(model_count), 32'd0);
        check("async_rst_sticky", 32'(err_sticky), 32'd0);
        check("async_rst_count",  32'(err_count), 32'd0);
        ref_q.delete();
        ref_st = '0;
        ref_ec = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h5A, 6'd0, 0);
        step(0, 1, 8'h00, 6'd0, 0);
        idle(2);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
